// File: rtl/click_record_reader_if.sv
// Record input and event output bundle of the click record reader.
// The master side produces records and consumes events; the slave side is the reader.
interface click_record_reader_if #(
    parameter int EPOCH_W = 12
);
    logic [40:0]          rec_data;
    logic                 rec_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_channel;
    logic [36+EPOCH_W-1:0] out_time;

    modport master (
        output rec_data, rec_ready, out_ready,
        input  out_valid, out_channel, out_time
    );

    modport slave (
        input  rec_data, rec_ready, out_ready,
        output out_valid, out_channel, out_time
    );
endinterface

// File: rtl/click_record_reader.sv
// Receive-side consumer of 41-bit click registration records.
// Extends the 36-bit timestamp with an epoch counter driven by wrap markers
// and buffers channel events in a first-word-fall-through FIFO.
module click_record_reader #(
    parameter int DEPTH_LOG2 = 4,
    parameter int EPOCH_W    = 12
) (
    input  logic                 clk,
    input  logic                 clear_n,
    click_record_reader_if.slave rec,
    output logic [15:0]          lost_count,
    output logic                 overflow
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TIME_W  = 36 + EPOCH_W;
    localparam int ENTRY_W = 4 + TIME_W;

    logic [EPOCH_W-1:0]  epoch;
    logic                armed;
    logic [EPOCH_W-1:0]  epoch_eff;
    logic                is_wrap;
    logic                is_event;
    logic [3:0]          rec_channel;
    logic                push;
    logic                pop;
    logic                drop;
    logic                full;
    logic                empty;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] count;
    logic [ENTRY_W-1:0]  head;

    // Record classification and push/pop/drop decisions; rec_data is only
    // looked at while rec_ready is high, so a floating bus never leaks in.
    always_comb begin
        rec_channel = rec.rec_data[40:37];
        is_wrap     = rec.rec_ready && rec.rec_data[36];
        is_event    = rec.rec_ready && (rec_channel != 4'b0000);
        epoch_eff   = (is_wrap && armed) ? epoch + EPOCH_W'(1) : epoch;
        full        = (count == (DEPTH_LOG2+1)'(DEPTH));
        empty       = (count == '0);
        pop         = !empty && rec.out_ready;
        push        = is_event && (!full || pop);
        drop        = is_event && full && !pop;
    end

    // Epoch tracking: the first marker only arms, later markers advance the epoch.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            epoch <= '0;
            armed <= 1'b0;
        end else if (is_wrap) begin
            armed <= 1'b1;
            epoch <= epoch_eff;
        end
    end

    // FIFO pointers and registered occupancy.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {rec_channel, epoch_eff, rec.rec_data[35:0]};
    end

    // Loss accounting for events arriving at a full FIFO with no pop.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            lost_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (lost_count != 16'hFFFF) lost_count <= lost_count + 16'd1;
        end
    end

    // Head presentation; forced to zero while empty so reset drives known values.
    always_comb begin
        head            = mem[rd_ptr[DEPTH_LOG2-1:0]];
        rec.out_valid   = !empty;
        rec.out_channel = empty ? 4'b0000 : head[ENTRY_W-1 -: 4];
        rec.out_time    = empty ? '0 : head[TIME_W-1:0];
    end
endmodule

// File: tb/tb_click_record_reader.sv
// Directed bench for click_record_reader with a scoreboard queue of expected events.
module tb_click_record_reader;
    localparam int EPOCH_W = 12;
    localparam int DEPTH   = 16;

    logic        clk = 1'b0;
    logic        clear_n;
    logic [15:0] lost_count;
    logic        overflow;

    click_record_reader_if #(.EPOCH_W(EPOCH_W)) bus ();

    click_record_reader #(.DEPTH_LOG2(4), .EPOCH_W(EPOCH_W)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .rec        (bus),
        .lost_count (lost_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [51:0]        exp_q[$];
    logic [EPOCH_W-1:0] m_epoch;
    logic               m_armed;
    logic [15:0]        m_lost;
    logic               m_ovf;
    logic               hold_pending;
    logic [3:0]         held_ch;
    logic [47:0]        held_time;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [40:0] rec(input logic [3:0] ch, input logic w, input logic [35:0] ts);
        return {ch, w, ts};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_epoch      = '0;
        m_armed      = 1'b0;
        m_lost       = '0;
        m_ovf        = 1'b0;
        hold_pending = 1'b0;
    endtask

    // Called negedge-aligned: check outputs, drive one cycle of stimulus, advance.
    task automatic tick(input logic rdy, input logic [40:0] d, input logic ordy);
        logic        pop_m;
        logic [51:0] hd;
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        chk("lost_count", 64'(lost_count), 64'(m_lost));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (hold_pending && bus.out_valid) begin
            chk("hold_channel", 64'(bus.out_channel), 64'(held_ch));
            chk("hold_time", 64'(bus.out_time), 64'(held_time));
        end
        pop_m = (exp_q.size() != 0) && ordy;
        if (pop_m) begin
            hd = exp_q.pop_front();
            chk("out_channel", 64'(bus.out_channel), 64'(hd[51:48]));
            chk("out_time", 64'(bus.out_time), 64'(hd[47:0]));
        end
        hold_pending = bus.out_valid && !ordy;
        held_ch      = bus.out_channel;
        held_time    = bus.out_time;

        bus.rec_ready = rdy;
        bus.rec_data  = rdy ? d : 41'bz;
        bus.out_ready = ordy;

        if (rdy) begin
            if (d[36]) begin
                if (m_armed) m_epoch = m_epoch + 1'b1;
                m_armed = 1'b1;
            end
            if (d[40:37] != 4'b0000) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({d[40:37], m_epoch, d[35:0]});
                else begin
                    if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) tick(1'b0, 41'd0, ordy);
    endtask

    // Async reset at mid-cycle, checks immediate effect, releases on next negedge.
    task automatic do_reset(input string tag);
        #2;
        clear_n = 1'b0;
        #1;
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_lost"}, 64'(lost_count), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_channel"}, 64'(bus.out_channel), 64'd0);
        chk({tag, "_time"}, 64'(bus.out_time), 64'd0);
        model_reset();
        bus.rec_ready = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        model_reset();
        clear_n       = 1'b0;
        bus.rec_ready = 1'b0;
        bus.rec_data  = 41'bz;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset("reset");
        @(negedge clk);

        // First marker arms, following event lands in epoch 0 and is visible next cycle
        tick(1'b1, rec(4'b0000, 1'b1, 36'h0), 1'b0);
        tick(1'b1, rec(4'b0001, 1'b0, 36'h10), 1'b0);
        tick(1'b0, 41'd0, 1'b1);
        idle(2, 1'b1);

        // Fresh run: three markers each followed by an event
        do_reset("reset2");
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, rec(4'b0000, 1'b1, 36'h0), 1'b1);
            tick(1'b1, rec(4'b0100, 1'b0, 36'h5), 1'b1);
        end
        idle(2, 1'b1);

        // One more marker (epoch 3), then wrap+event belongs to epoch 4
        tick(1'b1, rec(4'b0000, 1'b1, 36'h0), 1'b1);
        tick(1'b1, rec(4'b1000, 1'b1, 36'h0), 1'b1);
        idle(2, 1'b1);

        // Epoch counter wraps modulo 2^EPOCH_W: 4 + 4095 -> 3
        for (int i = 0; i < 4095; i++) tick(1'b1, rec(4'b0000, 1'b1, 36'h0), 1'b1);
        tick(1'b1, rec(4'b0010, 1'b0, 36'h123456789), 1'b1);
        idle(2, 1'b1);

        // Fill with downstream stalled: 16 stored, 2 lost
        for (int i = 0; i < 18; i++)
            tick(1'b1, rec(4'((i % 15) + 1), 1'b0, 36'h100 + 36'(i)), 1'b0);
        tick(1'b0, 41'd0, 1'b0);
        chk("lost_after_fill", 64'(lost_count), 64'd2);
        chk("overflow_after_fill", 64'(overflow), 64'd1);

        // Full with simultaneous pop: push accepted, nothing lost
        tick(1'b1, rec(4'b0001, 1'b0, 36'hABC), 1'b1);
        // Still full afterwards, so a stalled event is dropped
        tick(1'b1, rec(4'b0010, 1'b0, 36'hDEF), 1'b0);
        tick(1'b0, 41'd0, 1'b0);
        chk("lost_after_full_pushpop", 64'(lost_count), 64'd3);
        idle(20, 1'b1);
        chk("drained_valid", 64'(bus.out_valid), 64'd0);

        // Five queued entries discarded by mid-stream reset
        for (int i = 0; i < 5; i++) tick(1'b1, rec(4'b0011, 1'b0, 36'(i)), 1'b0);
        chk("queued_before_reset", 64'(bus.out_valid), 64'd1);
        do_reset("midreset");
        tick(1'b1, rec(4'b0000, 1'b1, 36'h0), 1'b0);
        tick(1'b1, rec(4'b0001, 1'b0, 36'h77), 1'b0);
        tick(1'b0, 41'd0, 1'b1);
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/click_record_reader.md
# click_record_reader

Receive-side consumer for the 41-bit pulse-registration records produced by the click registration stage. Takes one record per `rec_ready` strobe, tracks timer wrap-around via the wrap-marker bit to extend the 36-bit timestamp into an absolute time, and buffers channel events in a small first-word-fall-through FIFO. Events are presented downstream with a valid/ready handshake. Overflow losses are counted, never silent.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth = 2^DEPTH_LOG2 entries.
- `EPOCH_W`, default 12: width of the wrap (epoch) counter; extended time width = 36+EPOCH_W.
- `clk`  in  1  single system clock; all logic on posedge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `rec_data`  in  41  record: [35:0] timestamp, [36] wrap marker, [40:37] channel bitmask; don't-care/Z when `rec_ready` low.
- `rec_ready`  in  1  record strobe, one cycle per record; no backpressure possible upstream.
- `out_valid`  out  1  FIFO head holds an event.
- `out_ready`  in  1  downstream accepts head this cycle.
- `out_channel`  out  4  channel bitmask of head event.
- `out_time`  out  36+EPOCH_W  {epoch, timestamp} of head event.
- `lost_count`  out  16  events dropped on full FIFO, saturating at 16'hFFFF.
- `overflow`  out  1  sticky: at least one event dropped since reset.

## Operation
- Record classes when `rec_ready`=1: wrap-only (bit36=1, channel=0); event (channel≠0, bit36=0); wrap+event (both set; timestamp is 0).
- Epoch tracking: registers `epoch` (EPOCH_W) and `armed` (1).
  - Wrap marker with `armed`=0: set `armed`; `epoch` unchanged (first marker marks start of run, timer=0).
  - Wrap marker with `armed`=1: `epoch` <= `epoch`+1, modulo 2^EPOCH_W (wraps silently to 0).
  - Events before the first marker carry epoch 0.
- Event time: {epoch_eff, rec_data[35:0]} where epoch_eff is the epoch value after applying the same record's wrap marker (wrap+event belongs to the new epoch).
- Push: event or wrap+event record, and (FIFO not full, or simultaneous pop). Stored entry = {channel, extended time}.
- Drop: push condition false because FIFO full with no pop → entry discarded, `lost_count` saturating +1, `overflow` <= 1. Epoch update of that record still applied.
- Wrap-only records are never enqueued and never counted as lost.
- `rec_ready`=0: `rec_data` ignored entirely (may be Z).
- Pop: `out_valid` && `out_ready`. Head advances; next entry visible the following cycle.
- Push and pop same cycle: both occur, occupancy unchanged, including when full.
- FIFO: pointers DEPTH_LOG2+1 bits; full/empty from registered occupancy; `out_valid` = not empty.
- `out_channel`/`out_time` are don't-care when `out_valid`=0 and must be held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (`clear_n` low, async): `out_valid`=0, `lost_count`=0, `overflow`=0, `epoch`=0, `armed`=0, FIFO empty; `out_channel`/`out_time` driven 0. Takes effect immediately, mid-operation included; in-flight entries discarded.
- Reset release: first record sampled on the first posedge with `clear_n` high.
- Latency: event strobed at edge k into empty FIFO → `out_valid`=1 after edge k, with data valid in the same cycle.
- Throughput: one record accepted per cycle; one pop per cycle.
- Epoch update takes effect at the strobe edge; the next cycle's record sees the new epoch.
- `lost_count`/`overflow` update at the edge of the dropped strobe.

## Test plan
- Reset then wrap-only (ts 0), event ch 4'b0001 ts 36'h10 → one output, `out_time` = {12'h000, 36'h10}; `out_valid` after 1 cycle.
- Markers at ts 0 ×3 with events ch 4'b0100 ts 5 after each, `out_ready`=1 → times {0,5}, {1,5}, {2,5}; no wrap-only entries emitted.
- Wrap+event record (bit36=1, ch 4'b1000, ts 0) after armed at epoch 3 → `out_time` = {12'h004, 36'h0}, `out_channel`=4'b1000.
- `out_ready`=0, 18 events (DEPTH 16) → 16 buffered in order, `lost_count`=2, `overflow`=1; drain yields the first 16 unchanged.
- Full FIFO, push+pop same cycle → push accepted, `lost_count` unchanged, occupancy stays 16.
- Assert `clear_n` low mid-stream with 5 entries queued → `out_valid`=0 immediately, counters 0; next event after release carries epoch 0.
